registro_ex_mem: RTL and testbench

- Pipeline register directly downstream of the ULA. Captures the ULA result and flags, plus the write-back control for the instruction.
- Resolves blt/bgt branches from the captured `negativo` flag and produces the registered branch-taken pulse and target PC.
- Squashes the instructions in the branch shadow.
- Feeds the memory/write-back stage.

---
 rtl/registro_ex_mem.sv | 115 +++++++++++
 tb/tb_registro_ex_mem.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/registro_ex_mem.sv
`default_nettype none
// ============================================================================
// Module   : registro_ex_mem
// Purpose  : EX/MEM pipeline register. Captures ULA result and flags, resolves
//            blt/bgt from the captured sign flag, squashes the branch shadow.
//            Optional taken-branch counter under `CONTADOR_DESVIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module registro_ex_mem #(
    parameter int LARGURA = 32,
    parameter int BOLHAS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               stall,
    input  logic               flush,
    input  logic [LARGURA-1:0] result,
    input  logic               zero,
    input  logic               negativo,
    input  logic [1:0]         origULA,
    input  logic [2:0]         selec,
    input  logic [4:0]         rd_addr,
    input  logic               reg_write,
    input  logic [LARGURA-1:0] pc_in,
    input  logic [LARGURA-1:0] imed,
    output logic               ready_in,
    output logic               valid_out,
    output logic [LARGURA-1:0] result_out,
    output logic               zero_out,
    output logic               negativo_out,
    output logic [4:0]         rd_addr_out,
    output logic               reg_write_out,
    output logic               desvio,
    output logic [LARGURA-1:0] pc_desvio
`ifdef CONTADOR_DESVIO_EN
    ,
    output logic [31:0]        contador_desvio
`endif
);

    localparam logic [1:0] c_ORIG_CMP = 2'b10;
    localparam logic [2:0] c_SEL_BLT  = 3'b001;
    localparam logic [2:0] c_SEL_BGT  = 3'b010;
    localparam logic [2:0] c_BOLHAS   = 3'(BOLHAS);

    logic       w_accept;
    logic       w_is_cmp;
    logic       w_taken;
    logic       w_in_shadow;
    logic [2:0] r_sombra;

    assign ready_in    = ~stall;
    assign w_accept    = valid_in & ~stall & ~flush;
    assign w_is_cmp    = (origULA == c_ORIG_CMP);
    assign w_taken     = w_is_cmp && ((selec == c_SEL_BLT) || (selec == c_SEL_BGT)) && negativo;
    assign w_in_shadow = (r_sombra != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out     <= 1'b0;
            result_out    <= '0;
            zero_out      <= 1'b0;
            negativo_out  <= 1'b0;
            rd_addr_out   <= 5'd0;
            reg_write_out <= 1'b0;
            desvio        <= 1'b0;
            pc_desvio     <= '0;
            r_sombra      <= 3'd0;
        end else if (flush) begin
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            desvio        <= 1'b0;
            r_sombra      <= 3'd0;
        end else if (stall) begin
            // Everything holds so a pending desvio pulse survives the stall.
        end else if (w_accept) begin
            result_out   <= result;
            zero_out     <= zero;
            negativo_out <= negativo;
            rd_addr_out  <= rd_addr;
            if (w_in_shadow) begin
                valid_out     <= 1'b0;
                reg_write_out <= 1'b0;
                desvio        <= 1'b0;
                r_sombra      <= r_sombra - 3'd1;
            end else begin
                valid_out     <= 1'b1;
                reg_write_out <= reg_write & ~w_is_cmp;
                desvio        <= w_taken;
                if (w_taken) begin
                    pc_desvio <= pc_in + imed;
                    r_sombra  <= c_BOLHAS;
                end
            end
        end else begin
            // Idle cycles are not instructions, so the shadow count is kept.
            valid_out     <= 1'b0;
            reg_write_out <= 1'b0;
            desvio        <= 1'b0;
        end
    end

`ifdef CONTADOR_DESVIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contador_desvio <= 32'd0;
        end else if (w_accept && !w_in_shadow && w_taken) begin
            contador_desvio <= contador_desvio + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_registro_ex_mem.sv
`default_nettype none
// Testbench for registro_ex_mem: directed vectors, reference model, per-cycle compare.
module tb_registro_ex_mem;

    localparam int LARGURA = 32;
    localparam int BOLHAS  = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [LARGURA-1:0] result = '0, pc_in = '0, imed = '0;
    logic               zero = 1'b0, negativo = 1'b0, reg_write = 1'b0;
    logic [1:0]         origULA = 2'b00;
    logic [2:0]         selec = 3'b000;
    logic [4:0]         rd_addr = 5'd0;
    logic               ready_in, valid_out, zero_out, negativo_out, reg_write_out, desvio;
    logic [LARGURA-1:0] result_out, pc_desvio;
    logic [4:0]         rd_addr_out;
`ifdef CONTADOR_DESVIO_EN
    logic [31:0]        contador_desvio;
`endif

    registro_ex_mem #(.LARGURA(LARGURA), .BOLHAS(BOLHAS)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .stall(stall), .flush(flush),
        .result(result), .zero(zero), .negativo(negativo), .origULA(origULA),
        .selec(selec), .rd_addr(rd_addr), .reg_write(reg_write), .pc_in(pc_in),
        .imed(imed), .ready_in(ready_in), .valid_out(valid_out),
        .result_out(result_out), .zero_out(zero_out), .negativo_out(negativo_out),
        .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out), .desvio(desvio),
        .pc_desvio(pc_desvio)
`ifdef CONTADOR_DESVIO_EN
        , .contador_desvio(contador_desvio)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the stage, written from the priority rules.
    logic        m_valid, m_zero, m_neg, m_rw, m_desvio;
    logic [31:0] m_result, m_pc, m_cnt;
    logic [4:0]  m_rd;
    int          m_shadow;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_result <= 0; m_zero <= 0; m_neg <= 0; m_rd <= 0;
            m_rw <= 0; m_desvio <= 0; m_pc <= 0; m_shadow <= 0; m_cnt <= 0;
        end else if (flush) begin
            m_valid <= 0; m_rw <= 0; m_desvio <= 0; m_shadow <= 0;
        end else if (stall) begin
            m_valid <= m_valid;
        end else if (!valid_in) begin
            m_valid <= 0; m_rw <= 0; m_desvio <= 0;
        end else if (m_shadow > 0) begin
            m_valid <= 0; m_rw <= 0; m_desvio <= 0; m_shadow <= m_shadow - 1;
        end else begin
            m_valid  <= 1;
            m_result <= result; m_zero <= zero; m_neg <= negativo; m_rd <= rd_addr;
            m_rw     <= reg_write && (origULA != 2'b10);
            if (origULA == 2'b10 && (selec == 3'd1 || selec == 3'd2) && negativo) begin
                m_desvio <= 1;
                m_pc     <= pc_in + imed;
                m_shadow <= BOLHAS;
                m_cnt    <= m_cnt + 1;
            end else begin
                m_desvio <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
            chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, m_rw});
            chk("desvio", {31'd0, desvio}, {31'd0, m_desvio});
            chk("pc_desvio", pc_desvio, m_pc);
            chk("ready_in", {31'd0, ready_in}, {31'd0, ~stall});
            if (m_valid) begin
                chk("result_out", result_out, m_result);
                chk("zero_out", {31'd0, zero_out}, {31'd0, m_zero});
                chk("negativo_out", {31'd0, negativo_out}, {31'd0, m_neg});
                chk("rd_addr_out", {27'd0, rd_addr_out}, {27'd0, m_rd});
            end
`ifdef CONTADOR_DESVIO_EN
            chk("contador_desvio", contador_desvio, m_cnt);
`endif
        end
    end

    // Drive one cycle of inputs just after a rising edge, then wait for the next edge.
    task automatic cyc(input logic v, input logic st, input logic fl, input logic [31:0] res,
                       input logic [1:0] ou, input logic [2:0] se, input logic n,
                       input logic [4:0] rd, input logic rw, input logic [31:0] pc,
                       input logic [31:0] im);
        valid_in = v; stall = st; flush = fl; result = res; zero = (res == 0);
        origULA = ou; selec = se; negativo = n; rd_addr = rd; reg_write = rw;
        pc_in = pc; imed = im;
        @(posedge clk); #1;
    endtask

    task automatic alu(input logic [31:0] res, input logic [4:0] rd);
        cyc(1, 0, 0, res, 2'b00, 3'b001, 0, rd, 1, 32'h0, 32'h0);
    endtask

    task automatic br(input logic [2:0] se, input logic n, input logic [31:0] pc, input logic [31:0] im);
        cyc(1, 0, 0, 32'hFFFF_FFFF, 2'b10, se, n, 5'd7, 1, pc, im);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 32'h0, 2'b00, 3'b000, 0, 5'd0, 0, 32'h0, 32'h0);
    endtask

    logic [31:0] cnt0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_result", result_out, 32'd0);
        chk("rst_desvio", {31'd0, desvio}, 32'd0);
        chk("rst_pc_desvio", pc_desvio, 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // R-type pass-through
        alu(32'h0000_0005, 5'd3);
        chk("rtype_valid", {31'd0, valid_out}, 32'd1);
        chk("rtype_result", result_out, 32'd5);
        chk("rtype_rd", {27'd0, rd_addr_out}, 32'd3);
        chk("rtype_rw", {31'd0, reg_write_out}, 32'd1);
        chk("rtype_desvio", {31'd0, desvio}, 32'd0);

        // Taken blt and its two-instruction shadow
        br(3'b001, 1, 32'h40, 32'h10);
        chk("blt_desvio", {31'd0, desvio}, 32'd1);
        chk("blt_pc", pc_desvio, 32'h50);
        chk("blt_rw", {31'd0, reg_write_out}, 32'd0);
        idle();
        alu(32'h11, 5'd1);
        chk("shadow1_valid", {31'd0, valid_out}, 32'd0);
        br(3'b010, 1, 32'h100, 32'h4);
        chk("shadow2_branch_squashed", {31'd0, desvio}, 32'd0);
        alu(32'h33, 5'd3);
        chk("after_shadow_valid", {31'd0, valid_out}, 32'd1);
        chk("after_shadow_pc_held", pc_desvio, 32'h50);

        // Not-taken bgt, compare never writes, no shadow
        br(3'b010, 0, 32'h80, 32'h8);
        chk("bgt_nt_desvio", {31'd0, desvio}, 32'd0);
        chk("bgt_nt_valid", {31'd0, valid_out}, 32'd1);
        chk("bgt_nt_rw", {31'd0, reg_write_out}, 32'd0);
        alu(32'h44, 5'd4);
        chk("bgt_nt_next_valid", {31'd0, valid_out}, 32'd1);
        // Compare with a non-branch selec is a plain ALU op
        br(3'b011, 1, 32'h80, 32'h8);
        chk("cmp_other_desvio", {31'd0, desvio}, 32'd0);
        chk("cmp_other_valid", {31'd0, valid_out}, 32'd1);

        // Stall hold with changing inputs
        alu(32'hAAAA_AAAA, 5'd9);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 32'h1234_0000 + i, 2'b00, 3'b001, 0, 5'(i), 1, 32'h0, 32'h0);
            chk("stall_result", result_out, 32'hAAAA_AAAA);
            chk("stall_ready", {31'd0, ready_in}, 32'd0);
        end

        // Stall stretches a taken pulse; counter counts it once
`ifdef CONTADOR_DESVIO_EN
        cnt0 = contador_desvio;
`else
        cnt0 = 32'd0;
`endif
        br(3'b001, 1, 32'hFFFF_FFF0, 32'h20);
        chk("wrap_pc", pc_desvio, 32'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 32'h5, 2'b00, 3'b001, 0, 5'd2, 1, 32'h0, 32'h0);
            chk("stall_desvio", {31'd0, desvio}, 32'd1);
        end
`ifdef CONTADOR_DESVIO_EN
        chk("cnt_once", contador_desvio, cnt0 + 32'd1);
`endif
        idle();
        chk("stall_release_desvio", {31'd0, desvio}, 32'd0);
        alu(32'h6, 5'd6);
        alu(32'h7, 5'd7);
        alu(32'h8, 5'd8);
        chk("shadow_kept_over_idle", {31'd0, valid_out}, 32'd1);

        // Flush beats stall and clears the shadow
        br(3'b001, 1, 32'h200, 32'h40);
        cyc(1, 1, 1, 32'h9, 2'b00, 3'b001, 0, 5'd9, 1, 32'h0, 32'h0);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_desvio", {31'd0, desvio}, 32'd0);
        alu(32'hA, 5'd10);
        chk("post_flush_valid", {31'd0, valid_out}, 32'd1);
        chk("post_flush_result", result_out, 32'hA);

        // Asynchronous reset mid-shadow
        br(3'b010, 1, 32'h300, 32'h8);
        alu(32'hB, 5'd11);
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_result", result_out, 32'd0);
        chk("arst_desvio", {31'd0, desvio}, 32'd0);
        chk("arst_pc", pc_desvio, 32'd0);
`ifdef CONTADOR_DESVIO_EN
        chk("arst_cnt", contador_desvio, 32'd0);
`endif
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        alu(32'hC, 5'd12);
        chk("post_arst_valid", {31'd0, valid_out}, 32'd1);
        chk("post_arst_result", result_out, 32'hC);
        idle();
        idle();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
